// File: rtl/type_decoder_pipe.sv
// type_decoder_pipe
//   Registered, flow-controlled RV32I opcode-class decoder with a 2-entry
//   skid buffer (output register + one skid slot). in_ready is a flop output,
//   so there is no combinational path from out_ready to in_ready.
//
//   Optional feature macro: TYPE_DECODER_PERF_EN
//     defined   : 11 saturating per-class counters on out_fire, perf_clr clears
//     undefined : perf_cnt tied to 0, perf_clr ignored
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   in_valid   upstream instruction valid
//   in_ready   decoder can accept (= !skid_valid)
//   instr      instruction word
//   out_valid  decoded result valid
//   out_ready  downstream accepts
//   out_instr  instruction aligned with type_oh / illegal
//   type_oh    {system,fence,auipc,lui,jalr,jal,branch,store,load,i_type,r_type}
//   illegal    unrecognised opcode or instr[1:0] != 2'b11
//   perf_clr   synchronous clear of perf counters
//   perf_cnt   class k counter at [k*CNT_W +: CNT_W]

module type_decoder_pipe #(
   parameter int INSTR_W = 32,
   parameter int DEC_SYS = 0,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INSTR_W-1:0]   instr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INSTR_W-1:0]   out_instr,
   output logic [10:0]          type_oh,
   output logic                 illegal,
   input  logic                 perf_clr,
   output logic [11*CNT_W-1:0]  perf_cnt
);

   logic               skid_valid;
   logic [INSTR_W-1:0] skid_instr;
   logic [INSTR_W-1:0] sel_instr;
   logic [10:0]        dec_oh;
   logic               dec_ill;
   logic               in_fire;
   logic               out_fire;

   assign in_ready = !skid_valid;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // The skid slot always holds the older instruction, so it takes priority
   // when refilling the output register. in_fire cannot happen while it is full.
   assign sel_instr = skid_valid ? skid_instr : instr;

   always_comb begin
      dec_oh = '0;
      case (sel_instr[6:0])
         7'b0110011: dec_oh[0]  = 1'b1;
         7'b0010011: dec_oh[1]  = 1'b1;
         7'b0000011: dec_oh[2]  = 1'b1;
         7'b0100011: dec_oh[3]  = 1'b1;
         7'b1100011: dec_oh[4]  = 1'b1;
         7'b1101111: dec_oh[5]  = 1'b1;
         7'b1100111: dec_oh[6]  = 1'b1;
         7'b0110111: dec_oh[7]  = 1'b1;
         7'b0010111: dec_oh[8]  = 1'b1;
         7'b0001111: dec_oh[9]  = (DEC_SYS != 0);
         7'b1110011: dec_oh[10] = (DEC_SYS != 0);
         default:    dec_oh     = '0;
      endcase
      if (sel_instr[1:0] != 2'b11) begin
         dec_oh = '0;
      end
      dec_ill = (dec_oh == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         out_instr  <= '0;
         type_oh    <= '0;
         illegal    <= 1'b0;
         skid_valid <= 1'b0;
         skid_instr <= '0;
      end else begin
         if (!out_valid || out_fire) begin
            if (skid_valid || in_fire) begin
               out_valid <= 1'b1;
               out_instr <= sel_instr;
               type_oh   <= dec_oh;
               illegal   <= dec_ill;
            end else begin
               out_valid <= 1'b0;
            end
            skid_valid <= 1'b0;
         end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_instr <= instr;
         end
      end
   end

`ifdef TYPE_DECODER_PERF_EN
   logic [CNT_W-1:0] cnt [11];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 11; k++) cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 11; k++) begin
            if (perf_clr) begin
               cnt[k] <= '0;
            end else if (out_fire && type_oh[k] && (cnt[k] != '1)) begin
               cnt[k] <= cnt[k] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      perf_cnt = '0;
      for (int k = 0; k < 11; k++) perf_cnt[k*CNT_W +: CNT_W] = cnt[k];
   end
`else
   logic unused_perf_clr;
   assign unused_perf_clr = perf_clr;
   assign perf_cnt        = '0;
`endif

endmodule
